// File: rtl/regfile.sv
// regfile: 2**ADDR_WIDTH x DATA_WIDTH register file, two combinational read ports, one synchronous write port
// Ports: clk/rst (sync, active-high, clears all registers); raddr_a/rdata_a and raddr_b/rdata_b read ports;
//        we/waddr/wdata write port (no write-through; new data visible after the edge).
module regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);
  localparam int N = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [N];
  logic [DATA_WIDTH-1:0] regs_d [N];
  always_comb begin
    for (int i = 0; i < N; i++)
      regs_d[i] = rst ? '0 : (we && waddr == ADDR_WIDTH'(i)) ? wdata : regs_q[i];
  end
  always_ff @(posedge clk) regs_q <= regs_d;
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scoreboard bench for regfile
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst, we;
  logic [2:0]  raddr_a, raddr_b, waddr;
  logic [15:0] rdata_a, rdata_b, wdata;
  logic [15:0] mdl [8];
  logic [15:0] exp_q [$];
  int n_chk = 0;
  int n_fail = 0;
  regfile dut (
    .clk(clk), .rst(rst),
    .raddr_a(raddr_a), .rdata_a(rdata_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b),
    .we(we), .waddr(waddr), .wdata(wdata)
  );
  always #50 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    e = exp_q.pop_front();
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    exp_q.push_back(mdl[a]);
    exp_q.push_back(mdl[b]);
    raddr_a = a;
    raddr_b = b;
    #1;
    chk($sformatf("rd_a[%0d]", a), rdata_a);
    chk($sformatf("rd_b[%0d]", b), rdata_b);
  endtask
  task automatic sweep();
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i));
  endtask
  task automatic step();
    if (rst) for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    else if (we) mdl[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    rst = 1'b0; we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask
  initial begin
    raddr_a = '0; raddr_b = '0;
    rst = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 16'hFFFF;
    step();
    rst = 1'b0; we = 1'b0;
    sweep();
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
    sweep();
    wr(3'd5, 16'h1234);
    rst = 1'b0; we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
    rd(3'd5, 3'd5);
    step();
    we = 1'b0;
    rd(3'd5, 3'd5);
    wr(3'd2, 16'h0042);
    we = 1'b0; waddr = 3'd2; wdata = 16'hDEAD;
    step();
    sweep();
    wr(3'd1, 16'hAAAA);
    wr(3'd6, 16'h5555);
    rd(3'd1, 3'd6);
    rd(3'd6, 3'd6);
    rd(3'd0, 3'd1);
    wr(3'd4, 16'h7FFF);
    rd(3'd4, 3'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep();
    wr(3'd4, 16'h8001);
    rd(3'd4, 3'd3);
    wr(3'd7, 16'h0001);
    wr(3'd7, 16'hC3A5);
    rd(3'd7, 3'd4);
    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
